// File: rtl/scpad_req_arbiter.sv
// scpad_req_arbiter
//   Shares one scratchpad datapath port between the frontend (FE) and
//   backend (BE) requesters. A combinational arbiter picks a winner each
//   cycle, registers it into a sel_req stage tagged with its source, and an
//   in-order tag FIFO steers each returning sel_res back to its owner.
//
// Ports
//   CLK, nRST          clock (rising edge), asynchronous active-low reset
//   fe_req / fe_ready  FE request and accept strobe
//   be_req / be_ready  BE request and accept strobe
//   sel_req/sel_ready  registered request to the datapath and its consume strobe
//   sel_res            datapath response, always in issue order
//   fe_res / be_res    registered single-cycle response pulses to each owner
//   outstanding        live request count (issued, not yet answered)
//   src_err            sticky: response src mismatch or response with no tag

package scpad_pkg;
    localparam int XBAR_W = 8;
    localparam int DATA_W = 32;

    localparam logic SRC_FE = 1'b0;
    localparam logic SRC_BE = 1'b1;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [XBAR_W-1:0] xbar;
        logic [DATA_W-1:0] wdata;
    } req_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic              src;
        logic [XBAR_W-1:0] xbar;
        logic [DATA_W-1:0] wdata;
    } sel_req_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic              src;
        logic [DATA_W-1:0] rdata;
    } sel_res_t;

    typedef struct packed {
        logic              valid;
        logic              write;
        logic [DATA_W-1:0] rdata;
    } res_t;
endpackage

module scpad_req_arbiter
    import scpad_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8,
    parameter int STARVE_LIMIT    = 4
) (
    input  logic                             CLK,
    input  logic                             nRST,
    input  req_t                             fe_req,
    output logic                             fe_ready,
    input  req_t                             be_req,
    output logic                             be_ready,
    output sel_req_t                         sel_req,
    input  logic                             sel_ready,
    input  sel_res_t                         sel_res,
    output res_t                             fe_res,
    output res_t                             be_res,
    output logic [$clog2(MAX_OUTSTANDING):0] outstanding,
    output logic                             src_err
);
    localparam int PW = $clog2(MAX_OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Tag entry: {src, write}
    logic [1:0]    tag_q [MAX_OUTSTANDING];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [SW-1:0] starve_q, starve_d;
    sel_req_t      sel_q, sel_d;
    res_t          fe_res_q, fe_res_d, be_res_q, be_res_d;
    logic          err_q, err_d;

    logic empty, full, pop, push, load, gnt_fe, gnt_be;
    logic head_src;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(MAX_OUTSTANDING));
    // A response with no tag in flight is flagged but never pops.
    assign pop      = sel_res.valid && !empty;
    assign head_src = tag_q[rd_ptr_q][1];

    // Popping in the same cycle frees a slot, so a full FIFO can still accept.
    assign load = (!sel_q.valid || sel_ready) && (!full || pop);

    assign gnt_be = load && be_req.valid &&
                    (!fe_req.valid || starve_q == SW'(STARVE_LIMIT));
    assign gnt_fe = load && fe_req.valid && !gnt_be;
    assign push   = gnt_fe || gnt_be;

    assign fe_ready = gnt_fe;
    assign be_ready = gnt_be;

    always_comb begin
        starve_d = starve_q;
        if (!be_req.valid || gnt_be)
            starve_d = '0;
        else if (gnt_fe)
            starve_d = starve_q + 1'b1;

        sel_d = sel_q;
        if (gnt_be)
            sel_d = '{valid: 1'b1, write: be_req.write, src: SRC_BE,
                      xbar: be_req.xbar, wdata: be_req.wdata};
        else if (gnt_fe)
            sel_d = '{valid: 1'b1, write: fe_req.write, src: SRC_FE,
                      xbar: fe_req.xbar, wdata: fe_req.wdata};
        else if (sel_ready)
            sel_d.valid = 1'b0;

        cnt_d = cnt_q;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        // Routing follows the FIFO head even when the response src disagrees.
        fe_res_d = '0;
        be_res_d = '0;
        if (pop) begin
            if (head_src == SRC_FE)
                fe_res_d = '{valid: 1'b1, write: sel_res.write, rdata: sel_res.rdata};
            else
                be_res_d = '{valid: 1'b1, write: sel_res.write, rdata: sel_res.rdata};
        end

        err_d = err_q;
        if (sel_res.valid && (empty || sel_res.src != head_src))
            err_d = 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            starve_q <= '0;
            sel_q    <= '0;
            fe_res_q <= '0;
            be_res_q <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q    <= cnt_d;
            starve_q <= starve_d;
            sel_q    <= sel_d;
            fe_res_q <= fe_res_d;
            be_res_q <= be_res_d;
            err_q    <= err_d;
        end
    end

    // Tag storage needs no reset: occupancy is tracked by cnt_q and the pointers.
    always_ff @(posedge CLK) begin
        if (push)
            tag_q[wr_ptr_q] <= {(gnt_be ? SRC_BE : SRC_FE),
                                (gnt_be ? be_req.write : fe_req.write)};
    end

    assign sel_req     = sel_q;
    assign fe_res      = fe_res_q;
    assign be_res      = be_res_q;
    assign outstanding = cnt_q;
    assign src_err     = err_q;
endmodule

// File: tb/tb_scpad_req_arbiter.sv
module tb_scpad_req_arbiter;
    import scpad_pkg::*;

    localparam int MAXO = 8;
    localparam int SL   = 4;

    logic     CLK = 1'b0;
    logic     nRST = 1'b0;
    req_t     fe_req = '0, be_req = '0;
    logic     fe_ready, be_ready;
    sel_req_t sel_req;
    logic     sel_ready = 1'b0;
    sel_res_t sel_res = '0;
    res_t     fe_res, be_res;
    logic [$clog2(MAXO):0] outstanding;
    logic     src_err;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of source tags in issue order plus expected registers.
    logic     m_q[$];
    sel_req_t m_sel;
    res_t     m_fe, m_be;
    int       m_starve;
    logic     m_err;

    scpad_req_arbiter #(.MAX_OUTSTANDING(MAXO), .STARVE_LIMIT(SL)) dut (
        .CLK(CLK), .nRST(nRST),
        .fe_req(fe_req), .fe_ready(fe_ready),
        .be_req(be_req), .be_ready(be_ready),
        .sel_req(sel_req), .sel_ready(sel_ready),
        .sel_res(sel_res),
        .fe_res(fe_res), .be_res(be_res),
        .outstanding(outstanding), .src_err(src_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    function automatic req_t mk_req(input logic v);
        req_t r;
        r.valid = v;
        r.write = 1'($urandom);
        r.xbar  = XBAR_W'($urandom);
        r.wdata = $urandom;
        return r;
    endfunction

    function automatic sel_res_t mk_res(input logic v, input logic src, input logic [DATA_W-1:0] d);
        sel_res_t r;
        r.valid = v;
        r.write = 1'($urandom);
        r.src   = src;
        r.rdata = d;
        return r;
    endfunction

    function automatic sel_res_t good_res(input logic v);
        return mk_res(v && m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : SRC_FE, $urandom);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_sel = '0; m_fe = '0; m_be = '0;
        m_starve = 0; m_err = 1'b0;
    endtask

    // One clock: check registered outputs against the model, drive inputs,
    // check the grant, then advance the model to the post-edge state.
    task automatic cycle(input req_t fr, input req_t br, input logic srdy, input sel_res_t rs);
        logic pop, can, gf, gb, h;
        @(negedge CLK);
        chk("sel_req", sel_req, m_sel);
        chk("fe_res", fe_res, m_fe);
        chk("be_res", be_res, m_be);
        chk("outstanding", 64'(outstanding), 64'(m_q.size()));
        chk("src_err", src_err, m_err);
        fe_req = fr; be_req = br; sel_ready = srdy; sel_res = rs;
        #1;
        pop = rs.valid && m_q.size() > 0;
        can = (!m_sel.valid || srdy) && (m_q.size() < MAXO || pop);
        gb  = can && br.valid && (!fr.valid || m_starve == SL);
        gf  = can && fr.valid && !gb;
        chk("fe_ready", fe_ready, gf);
        chk("be_ready", be_ready, gb);
        m_fe = '0; m_be = '0;
        if (rs.valid) begin
            if (m_q.size() == 0) m_err = 1'b1;
            else begin
                h = m_q.pop_front();
                if (rs.src != h) m_err = 1'b1;
                if (h == SRC_FE) m_fe = '{valid: 1'b1, write: rs.write, rdata: rs.rdata};
                else             m_be = '{valid: 1'b1, write: rs.write, rdata: rs.rdata};
            end
        end
        if (gb) begin
            m_q.push_back(SRC_BE);
            m_sel = '{valid: 1'b1, write: br.write, src: SRC_BE, xbar: br.xbar, wdata: br.wdata};
            m_starve = 0;
        end else if (gf) begin
            m_q.push_back(SRC_FE);
            m_sel = '{valid: 1'b1, write: fr.write, src: SRC_FE, xbar: fr.xbar, wdata: fr.wdata};
            if (br.valid) m_starve++;
        end else if (srdy) begin
            m_sel.valid = 1'b0;
        end
        if (!br.valid) m_starve = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, 1'b1, '0);
    endtask

    // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
    task automatic do_reset();
        @(negedge CLK);
        #2 nRST = 1'b0;
        #1;
        chk("rst_sel_req", sel_req, '0);
        chk("rst_fe_res", fe_res, '0);
        chk("rst_be_res", be_res, '0);
        chk("rst_outstanding", 64'(outstanding), 0);
        chk("rst_src_err", src_err, 1'b0);
        model_reset();
        fe_req = '0; be_req = '0; sel_res = '0; sel_ready = 1'b0;
        @(negedge CLK);
        nRST = 1'b1;
    endtask

    initial begin
        model_reset();
        #12 nRST = 1'b1;

        // FE alone for three cycles.
        for (int i = 0; i < 3; i++) begin
            cycle(mk_req(1'b1), '0, 1'b1, '0);
            chk("fe_only_ready", fe_ready, 1'b1);
        end
        idle(1);
        chk("fe_only_outstanding", 64'(outstanding), 3);

        // Contended grants: FE x4 then BE, repeating.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(mk_req(1'b1), mk_req(1'b1), 1'b1, good_res(1'b1));
            chk("grant_order", be_ready, (i % 5) == 4);
        end
        idle(MAXO);

        // Randomized traffic with in-order, correctly tagged responses.
        for (int i = 0; i < 400; i++)
            cycle(mk_req(1'($urandom_range(0, 3) != 0)), mk_req(1'($urandom_range(0, 2) != 0)),
                  1'($urandom_range(0, 3) != 0), good_res(1'($urandom_range(0, 1))));
        for (int i = 0; i < 2 * MAXO; i++) cycle('0, '0, 1'b1, good_res(1'b1));

        // Fill to the limit, then pop and push in the same cycle.
        do_reset();
        for (int i = 0; i < MAXO + 2; i++) cycle(mk_req(1'b1), '0, 1'b1, '0);
        chk("full_fe_ready", fe_ready, 1'b0);
        chk("full_outstanding", 64'(outstanding), MAXO);
        cycle(mk_req(1'b1), mk_req(1'b1), 1'b1, mk_res(1'b1, SRC_FE, 32'h55));
        chk("full_swap_ready", fe_ready, 1'b1);
        idle(1);
        chk("full_swap_outstanding", 64'(outstanding), MAXO);

        // Response steering FE,BE,FE with rdata A,B,C.
        do_reset();
        cycle(mk_req(1'b1), '0, 1'b1, '0);
        cycle('0, mk_req(1'b1), 1'b1, '0);
        cycle(mk_req(1'b1), '0, 1'b1, '0);
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_FE, 32'hA));
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_BE, 32'hB));
        chk("order_A", {fe_res.valid, fe_res.rdata}, {1'b1, 32'hA});
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_FE, 32'hC));
        chk("order_B", {be_res.valid, be_res.rdata}, {1'b1, 32'hB});
        chk("order_B_fe_idle", fe_res.valid, 1'b0);
        idle(1);
        chk("order_C", {fe_res.valid, fe_res.rdata}, {1'b1, 32'hC});

        // Source mismatch: error is sticky, routing follows the head.
        cycle(mk_req(1'b1), '0, 1'b1, '0);
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_BE, 32'hD));
        idle(1);
        chk("mismatch_err", src_err, 1'b1);
        chk("mismatch_fe_res", {fe_res.valid, fe_res.rdata}, {1'b1, 32'hD});
        idle(3);
        chk("mismatch_sticky", src_err, 1'b1);

        // Reset with five in flight, then a fresh request and a stale response.
        for (int i = 0; i < 5; i++) cycle(mk_req(1'b1), '0, 1'b1, '0);
        idle(1);
        chk("pre_reset_outstanding", 64'(outstanding), 5);
        do_reset();
        cycle(mk_req(1'b1), '0, 1'b1, '0);
        chk("post_reset_ready", fe_ready, 1'b1);
        idle(1);
        chk("post_reset_issue", sel_req.valid, 1'b1);
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_FE, 32'h1));
        cycle('0, '0, 1'b1, mk_res(1'b1, SRC_FE, 32'h2));
        idle(1);
        chk("stale_res_err", src_err, 1'b1);
        chk("stale_res_outstanding", 64'(outstanding), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
